// File: rtl/pp_mode_ctrl_if.sv
// Pixel-side bus of pp_mode_ctrl: mode request, pixel valid/enable handshake and status outputs.
// The master modport is the upstream/driver side; the slave modport is the controller.
interface pp_mode_ctrl_if #(
    parameter int HW = 10,
    parameter int VW = 9
);
    logic          i_mode_sel;
    logic          i_pix_valid;
    logic          o_pp_en;
    logic          o_mode;
    logic [HW-1:0] o_hcount;
    logic [VW-1:0] o_vcount;
    logic          o_frame_done;
    logic          o_busy;
    logic          o_err;

    modport master (
        output i_mode_sel, i_pix_valid,
        input  o_pp_en, o_mode, o_hcount, o_vcount, o_frame_done, o_busy, o_err
    );

    modport slave (
        input  i_mode_sel, i_pix_valid,
        output o_pp_en, o_mode, o_hcount, o_vcount, o_frame_done, o_busy, o_err
    );
endinterface

// File: rtl/pp_mode_ctrl.sv
// Frame-synchronous mode controller: applies mode changes only at frame ends, after a drain stall.
// Optional sticky overrun detection is built when PP_MODE_ERR_EN is defined.
module pp_mode_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    pp_mode_ctrl_if.slave bus,
    output logic [1:0] o_dbg_state
);
    localparam int HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int VW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        SWITCH = 2'd3
    } state_t;

    state_t        state;
    logic          pp_en;
    logic          mode;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          frame_done;
    logic          busy;
    logic [3:0]    drain_cnt;

    // Handshake: a pixel transfers on a rising edge where i_pix_valid and o_pp_en are both high;
    // upstream must hold its pixel while o_pp_en is low, and o_pp_en never depends on i_pix_valid.
    logic xfer;
    logic h_last;
    logic v_last;

    assign xfer   = bus.i_pix_valid & pp_en;
    assign h_last = (hcount == HW'(H_ACTIVE - 1));
    assign v_last = (vcount == VW'(V_ACTIVE - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state      <= INIT;
            pp_en      <= 1'b0;
            mode       <= 1'b0;
            hcount     <= '0;
            vcount     <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                INIT: begin
                    mode  <= bus.i_mode_sel;
                    pp_en <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    if (xfer) begin
                        if (h_last) begin
                            hcount <= '0;
                            if (v_last) begin
                                vcount     <= '0;
                                frame_done <= 1'b1;
                                // Only the request level at the frame's last pixel matters.
                                if (bus.i_mode_sel != mode) begin
                                    state     <= DRAIN;
                                    pp_en     <= 1'b0;
                                    busy      <= 1'b1;
                                    drain_cnt <= 4'(FLUSH_CYCLES - 1);
                                end
                            end else begin
                                vcount <= vcount + 1'b1;
                            end
                        end else begin
                            hcount <= hcount + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state <= SWITCH;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                SWITCH: begin
                    // Reloads the live request, so a request withdrawn during DRAIN keeps the old mode.
                    mode  <= bus.i_mode_sel;
                    pp_en <= 1'b1;
                    busy  <= 1'b0;
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

`ifdef PP_MODE_ERR_EN
    logic err;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            err <= 1'b0;
        end else if (((state == DRAIN) || (state == SWITCH)) && bus.i_pix_valid) begin
            err <= 1'b1;
        end
    end

    assign bus.o_err = err;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_pp_en      = pp_en;
    assign bus.o_mode       = mode;
    assign bus.o_hcount     = hcount;
    assign bus.o_vcount     = vcount;
    assign bus.o_frame_done = frame_done;
    assign bus.o_busy       = busy;
    assign o_dbg_state      = state;
endmodule

// File: tb/tb_pp_mode_ctrl.sv
// Directed bench for pp_mode_ctrl (H_ACTIVE=4, V_ACTIVE=2, FLUSH_CYCLES=2) with a pixel scoreboard.
// Expected {mode, vcount, hcount} per pixel is queued by the driver and popped by the monitor on transfer.
module tb_pp_mode_ctrl;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FL = 2;
  localparam int HW = 2;
  localparam int VW = 1;
  localparam int W  = 1 + VW + HW;

  logic clk;
  logic rstn;
  logic [1:0] dbg_state;

  pp_mode_ctrl_if #(.HW(HW), .VW(VW)) bus ();

  pp_mode_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .FLUSH_CYCLES(FL)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  logic expect_fd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pix(input logic m, input int idx);
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    h = HW'(idx % H);
    v = VW'(idx / H);
    return {m, v, h};
  endfunction

  task automatic push_pixels(input logic m, input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pix(m, first + i));
  endtask

  // monitor: pops on each transfer, and checks frame_done in the cycle after the last pixel
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rstn) begin
      expect_fd = 1'b0;
    end else begin
      check("frame_done", 32'(bus.o_frame_done), 32'(expect_fd));
      expect_fd = 1'b0;
      if (bus.i_pix_valid && bus.o_pp_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 32'({bus.o_mode, bus.o_vcount, bus.o_hcount}), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pixel_mode_v_h", 32'({bus.o_mode, bus.o_vcount, bus.o_hcount}), 32'(e));
          if (e[HW+VW-1:0] == {VW'(V - 1), HW'(H - 1)}) expect_fd = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic send_pixels(input int n, output int cycles);
    int got;
    got    = 0;
    cycles = 0;
    bus.i_pix_valid = 1'b1;
    while (got < n && cycles < 200) begin
      @(negedge clk);
      if (bus.o_pp_en) got++;
      cycles++;
      @(posedge clk);
      #1;
    end
    bus.i_pix_valid = 1'b0;
    if (got < n) check("send_timeout", 32'(got), 32'(n));
  endtask

  task automatic do_reset(input logic m);
    bus.i_pix_valid = 1'b0;
    bus.i_mode_sel  = m;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    @(negedge clk);
    check("rst_pp_en", 32'(bus.o_pp_en), 32'd0);
    check("rst_mode", 32'(bus.o_mode), 32'd0);
    check("rst_counts", 32'({bus.o_vcount, bus.o_hcount}), 32'd0);
    check("rst_busy_fd", 32'({bus.o_busy, bus.o_frame_done}), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("init_pp_en", 32'(bus.o_pp_en), 32'd0);
    check("init_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    check("run_pp_en", 32'(bus.o_pp_en), 32'd1);
    check("run_mode", 32'(bus.o_mode), 32'(m));
    check("run_counts", 32'({bus.o_vcount, bus.o_hcount}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // stimulus
  initial begin
    int cyc;
    rstn = 1'b0;
    bus.i_mode_sel  = 1'b0;
    bus.i_pix_valid = 1'b0;

    // reset with mode 1 requested, then one frame back-to-back
    do_reset(1'b1);
    push_pixels(1'b1, 0, 8);
    send_pixels(8, cyc);
    check("frame_no_bubble", 32'(cyc), 32'd8);

    // request pulses 1 then back to 0 within a frame: no switch, no boundary bubble
    do_reset(1'b0);
    push_pixels(1'b0, 0, 8);
    send_pixels(2, cyc);
    bus.i_mode_sel = 1'b1;
    send_pixels(2, cyc);
    bus.i_mode_sel = 1'b0;
    send_pixels(4, cyc);
    push_pixels(1'b0, 0, 1);
    send_pixels(1, cyc);
    check("pulse_boundary_cycles", 32'(cyc), 32'd1);
    check("pulse_busy", 32'(bus.o_busy), 32'd0);
    push_pixels(1'b0, 1, 7);
    send_pixels(7, cyc);
    check("pulse_tail_cycles", 32'(cyc), 32'd7);

    // request 0->1 after pixel 3: mode held to frame end, then 3-cycle stall
    push_pixels(1'b0, 0, 8);
    send_pixels(3, cyc);
    bus.i_mode_sel = 1'b1;
    send_pixels(5, cyc);
    for (int k = 1; k <= FL + 1; k++) begin
      @(negedge clk);
      check("stall_pp_en", 32'(bus.o_pp_en), 32'd0);
      check("stall_busy", 32'(bus.o_busy), 32'd1);
      check("stall_mode_old", 32'(bus.o_mode), 32'd0);
    end
    @(negedge clk);
    check("switch_pp_en", 32'(bus.o_pp_en), 32'd1);
    check("switch_mode", 32'(bus.o_mode), 32'd1);
    check("switch_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk);
    #1;
    push_pixels(1'b1, 0, 8);
    send_pixels(8, cyc);
    check("new_mode_frame_cycles", 32'(cyc), 32'd8);

    // reset asserted during DRAIN
    bus.i_mode_sel = 1'b0;
    push_pixels(1'b1, 0, 8);
    send_pixels(8, cyc);
    @(negedge clk);
    check("drain_busy", 32'(bus.o_busy), 32'd1);
    check("drain_state", 32'(dbg_state), 32'd2);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    bus.i_mode_sel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("drain_rst_pp_en", 32'(bus.o_pp_en), 32'd0);
    check("drain_rst_busy", 32'(bus.o_busy), 32'd0);
    check("drain_rst_counts", 32'({bus.o_vcount, bus.o_hcount}), 32'd0);
    check("drain_rst_mode", 32'(bus.o_mode), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("drain_init_pp_en", 32'(bus.o_pp_en), 32'd0);
    @(negedge clk);
    check("drain_init_mode", 32'(bus.o_mode), 32'd1);
    check("drain_init_pp_en2", 32'(bus.o_pp_en), 32'd1);
    @(posedge clk);
    #1;
    push_pixels(1'b1, 0, 8);
    send_pixels(8, cyc);
    check("restart_frame_cycles", 32'(cyc), 32'd8);

    // valid held high through a switch stall
    check("err_before", 32'(bus.o_err), 32'd0);
    bus.i_mode_sel = 1'b0;
    push_pixels(1'b1, 0, 8);
    push_pixels(1'b0, 0, 8);
    send_pixels(16, cyc);
    check("held_valid_cycles", 32'(cyc), 32'(16 + FL + 1));
`ifdef PP_MODE_ERR_EN
    check("err_sticky", 32'(bus.o_err), 32'd1);
`else
    check("err_tied_low", 32'(bus.o_err), 32'd0);
`endif

    do_reset(1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pp_mode_ctrl.md
# pp_mode_ctrl

Frame-synchronous controller for the preprocessing stage. It counts accepted pixels to track frame position and latches the operating mode (0 = color passthrough, 1 = greyscale) only at frame boundaries, so a frame is never split between modes. On a pending change it stalls pixel input for one drain window so the preprocessing pipeline empties before the select flips. It sits between the capture-side pixel FIFO and the preprocessing mux, driving its mode select and input enable.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- FLUSH_CYCLES, 2, drain window in cycles; must be at least the preprocessing latency, range 1..15
- i_clk  in  1  clock
- i_rstn  in  1  reset, synchronous, active-low
- i_mode_sel  in  1  requested mode, level, already synchronized to i_clk
- i_pix_valid  in  1  upstream presents a pixel this cycle
- o_pp_en  out  1  pixel accept enable; a pixel transfers when i_pix_valid & o_pp_en
- o_mode  out  1  applied mode select to the preprocessing mux
- o_hcount  out  $clog2(H_ACTIVE)  column of the next pixel to be accepted
- o_vcount  out  $clog2(V_ACTIVE)  line of the next pixel to be accepted
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame transfers
- o_busy  out  1  high in DRAIN and SWITCH
- o_err  out  1  sticky overrun flag (see Configuration)

## Operation
- States: INIT, RUN, DRAIN, SWITCH.
- INIT: entered on reset for exactly 1 cycle. o_mode <= i_mode_sel, then go to RUN.
- RUN: o_pp_en = 1. On each transfer, o_hcount increments.
  - At H_ACTIVE-1, o_hcount wraps to 0 and o_vcount increments.
  - At the last pixel (H_ACTIVE-1, V_ACTIVE-1), both counters wrap to 0 and o_frame_done pulses.
  - On that same edge, if i_mode_sel != o_mode, go to DRAIN. Otherwise stay in RUN.
- DRAIN: o_pp_en = 0. The drain counter loads FLUSH_CYCLES-1 on entry and decrements each cycle; at 0, go to SWITCH.
- SWITCH: o_pp_en = 0, 1 cycle. o_mode <= i_mode_sel as sampled this cycle, then go to RUN.
- i_mode_sel changes mid-frame are ignored until the frame end. A request that reverts before frame end causes no switch.
- A request that reverts during DRAIN still completes DRAIN/SWITCH. SWITCH reloads the current value, so o_mode is unchanged in that case.
- Pixels presented while o_pp_en = 0 are not transferred and not counted. Upstream must hold them.
- o_pp_en, o_mode, o_frame_done and o_busy are registered outputs. Counters are registered.

## Timing
- Reset values: o_pp_en 0, o_mode 0, o_hcount 0, o_vcount 0, o_frame_done 0, o_busy 0, o_err 0, state INIT.
- The first cycle after reset release is INIT. o_pp_en = 1 from the second cycle.
- Last-pixel transfer on edge N: o_frame_done = 1 in cycle N+1 only, counters = 0 in cycle N+1.
- With a switch pending at edge N:
  - o_pp_en = 0 and o_busy = 1 for cycles N+1 .. N+FLUSH_CYCLES+1.
  - The new o_mode and o_pp_en = 1 appear together in cycle N+FLUSH_CYCLES+2.
  - Total stall is FLUSH_CYCLES+1 cycles.
- Without a pending switch, o_pp_en stays 1 across the frame boundary with zero bubbles.
- Reset asserted mid-frame or mid-DRAIN: all outputs return to reset values on the next edge, and the frame restarts at (0,0).
- Counter wrap and the frame-done pulse on the same edge are a single event. No extra cycle is inserted.

## Configuration
- PP_MODE_ERR_EN defined:
  - o_err sets when i_pix_valid = 1 while o_pp_en = 0 in RUN-adjacent stall cycles (DRAIN or SWITCH).
  - o_err then holds until reset. It signals that upstream is not honoring the enable.
- PP_MODE_ERR_EN undefined: o_err is tied to 0 and no detection logic is built.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=2, FLUSH_CYCLES=2.
- Reset, then i_mode_sel=1 held → o_mode=1 from cycle 2, o_pp_en=1 from cycle 2, counters 0.
- 8 back-to-back valid pixels, mode constant → o_hcount 0,1,2,3,0,1,2,3 and o_vcount 0,0,0,0,1,1,1,1; o_frame_done pulses once, cycle after pixel 8; no o_pp_en drop.
- Toggle i_mode_sel 0→1 after pixel 3 of a frame → o_mode stays 0 through pixel 8; then o_pp_en=0 for 3 cycles, o_busy=1 for 3 cycles, and o_mode=1 with o_pp_en=1 on the 4th cycle.
- i_mode_sel pulses 0→1→0 within one frame → no DRAIN, o_mode stays 0, no stall at the boundary.
- Reset asserted during DRAIN → next cycle o_pp_en=0, o_busy=0, counters 0; INIT reloads o_mode from i_mode_sel.
- With PP_MODE_ERR_EN, valid held high through DRAIN → o_err=1 from the cycle after the first stalled valid, held until reset; without the macro, o_err stays 0.
